// File: rtl/serial_frame_rx.sv
// serial_frame_rx: deserialises start/data/parity/stop frames into a handshaked parallel word
module serial_frame_rx #(
  parameter int WIDTH = 4,
  parameter int PARITY = 1
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             SIN,
  input  logic             SEN,
  input  logic             ACK,
  output logic [WIDTH-1:0] Q,
  output logic             VALID,
  output logic             PERR,
  output logic             FERR,
  output logic             OVR
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;
  state_t state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0] cnt;
  logic par;
  always_ff @(posedge CP) begin
    if (CR) begin
      state <= IDLE;
      shreg <= '0;
      cnt <= '0;
      par <= 1'b0;
      Q <= '0;
      VALID <= 1'b0;
      PERR <= 1'b0;
      FERR <= 1'b0;
      OVR <= 1'b0;
    end else begin
      PERR <= 1'b0;
      FERR <= 1'b0;
      if (ACK && VALID) VALID <= 1'b0;
      if (SEN) begin
        case (state)
          IDLE: if (!SIN) begin
            state <= DATA;
            shreg <= '0;
            cnt <= '0;
            par <= 1'b0;
          end
          DATA: begin
            shreg <= {shreg[WIDTH-2:0], SIN};
            par <= par ^ SIN;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state <= (PARITY != 0) ? PAR : STOP;
          end
          PAR: begin
            par <= par ^ SIN;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            // a good frame completing alongside ACK replaces the word instead of clearing VALID
            if (!SIN) FERR <= 1'b1;
            else if ((PARITY != 0) && par) PERR <= 1'b1;
            else if (!VALID || ACK) begin
              Q <= shreg;
              VALID <= 1'b1;
            end else OVR <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed frames with a scoreboard of accepted words
module tb_serial_frame_rx;
  logic CP, CR, SIN, SEN, ACK;
  logic [3:0] Q;
  logic VALID, PERR, FERR, OVR;
  int checks = 0;
  int failures = 0;
  logic [3:0] sb[$];
  logic [3:0] last_q = 4'd0;
  logic pre_valid;

  serial_frame_rx #(.WIDTH(4), .PARITY(1)) dut (
    .CP(CP), .CR(CR), .SIN(SIN), .SEN(SEN), .ACK(ACK),
    .Q(Q), .VALID(VALID), .PERR(PERR), .FERR(FERR), .OVR(OVR)
  );

  initial begin
    CP = 1'b0;
    forever #5 CP = ~CP;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic i, input logic a);
    @(negedge CP);
    SEN = s;
    SIN = i;
    ACK = a;
    @(posedge CP);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CP);
    CR = 1'b1;
    SEN = 1'b0;
    SIN = 1'b1;
    ACK = 1'b0;
    @(posedge CP);
    #1;
    @(negedge CP);
    CR = 1'b0;
    last_q = 4'd0;
    sb.delete();
  endtask

  task automatic frame(input logic [3:0] d, input bit bad_par, input logic stop,
                       input bit ack_stop, input bit gap, output logic v_pre);
    logic [6:0] bits;
    bits = {1'b0, d, (^d) ^ bad_par, stop};
    v_pre = 1'b0;
    for (int k = 6; k >= 0; k--) begin
      if (k == 0) v_pre = VALID;
      step(1'b1, bits[k], (k == 0) ? ack_stop : 1'b0);
      if (gap && k != 0) step(1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic pe,
                            input logic fe, input logic ov);
    if (sb.size() != 0) last_q = sb.pop_front();
    chk({tag, "_q"}, Q, last_q);
    chk({tag, "_valid"}, VALID, v);
    chk({tag, "_perr"}, PERR, pe);
    chk({tag, "_ferr"}, FERR, fe);
    chk({tag, "_ovr"}, OVR, ov);
  endtask

  initial begin
    CR = 1'b0; SEN = 1'b0; SIN = 1'b1; ACK = 1'b0;
    do_reset();
    expect_out("reset", 0, 0, 0, 0);

    sb.push_back(4'b1011);
    frame(4'b1011, 0, 1, 0, 0, pre_valid);
    chk("good_prestop_valid", pre_valid, 0);
    expect_out("good", 1, 0, 0, 0);
    step(1'b0, 1'b1, 1'b1);
    expect_out("good_ack", 0, 0, 0, 0);

    frame(4'b1011, 1, 1, 0, 0, pre_valid);
    expect_out("perr", 0, 1, 0, 0);
    step(1'b0, 1'b1, 1'b0);
    expect_out("perr_pulse_end", 0, 0, 0, 0);

    sb.push_back(4'b0110);
    frame(4'b0110, 0, 1, 0, 0, pre_valid);
    expect_out("after_perr", 1, 0, 0, 0);
    step(1'b0, 1'b1, 1'b1);
    chk("after_perr_ack_valid", VALID, 0);

    frame(4'b1100, 0, 0, 0, 0, pre_valid);
    expect_out("ferr", 0, 0, 1, 0);
    step(1'b1, 1'b1, 1'b0);
    expect_out("ferr_pulse_end", 0, 0, 0, 0);

    sb.push_back(4'b1011);
    frame(4'b1011, 0, 1, 0, 0, pre_valid);
    expect_out("ovr_first", 1, 0, 0, 0);
    frame(4'b0001, 0, 1, 0, 0, pre_valid);
    expect_out("ovr_drop", 1, 0, 0, 1);
    sb.push_back(4'b1100);
    frame(4'b1100, 0, 1, 1, 0, pre_valid);
    expect_out("ack_on_stop", 1, 0, 0, 1);
    step(1'b0, 1'b1, 1'b1);
    expect_out("ovr_sticky_ack", 0, 0, 0, 1);

    sb.push_back(4'b1011);
    frame(4'b1011, 0, 1, 0, 1, pre_valid);
    chk("gap_prestop_valid", pre_valid, 0);
    expect_out("gap", 1, 0, 0, 1);

    do_reset();
    expect_out("reset_valid", 0, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    do_reset();
    sb.push_back(4'b0101);
    frame(4'b0101, 0, 1, 0, 0, pre_valid);
    expect_out("after_midreset", 1, 0, 0, 0);

    do_reset();
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, 1'b0);
      chk("idle_outputs", {Q, VALID, PERR, FERR, OVR}, 8'd0);
    end
    sb.push_back(4'b1001);
    frame(4'b1001, 0, 1, 0, 0, pre_valid);
    expect_out("after_idle", 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
